// File: rtl/prince_arb_ctrl.sv
// Sequencing controller and two-client round-robin arbiter in front of a single PRINCE core.
// Define PRINCE_ARB_STATS_EN to add per-client completion counters (c0_ops, c1_ops, stats_clr).
module prince_arb_ctrl #(
    parameter int unsigned CORE_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         c0_valid,
    output logic         c0_ready,
    input  logic         c0_enc,
    input  logic [63:0]  c0_data,
    input  logic [127:0] c0_key,
    input  logic         c1_valid,
    output logic         c1_ready,
    input  logic         c1_enc,
    input  logic [63:0]  c1_data,
    input  logic [127:0] c1_key,
    output logic         c0_rsp_valid,
    input  logic         c0_rsp_ready,
    output logic         c1_rsp_valid,
    input  logic         c1_rsp_ready,
    output logic [63:0]  rsp_data,
    output logic         core_enc,
    output logic [63:0]  core_in,
    output logic [127:0] core_key,
    input  logic [63:0]  core_out,
    output logic         busy
`ifdef PRINCE_ARB_STATS_EN
    ,
    input  logic         stats_clr,
    output logic [15:0]  c0_ops,
    output logic [15:0]  c1_ops
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);

    state_e       state_q, state_d;
    logic         rrPtr_q, rrPtr_d;
    logic         owner_q, owner_d;
    logic [3:0]   latCnt_q, latCnt_d;
    logic         coreEnc_q;
    logic [63:0]  coreIn_q;
    logic [127:0] coreKey_q;
    logic [63:0]  rspData_q;

    logic         anyValid;
    logic         grant;
    logic         ownerRspReady;
    logic         loadOps;
    logic         captureOut;

    // Next-state logic; grant favours rrPtr_q only when both clients contend.
    always_comb begin
        anyValid      = c0_valid | c1_valid;
        grant         = (c0_valid & c1_valid) ? rrPtr_q : c1_valid;
        ownerRspReady = owner_q ? c1_rsp_ready : c0_rsp_ready;
        state_d       = state_q;
        rrPtr_d       = rrPtr_q;
        owner_d       = owner_q;
        latCnt_d      = latCnt_q;
        loadOps       = 1'b0;
        captureOut    = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    loadOps  = 1'b1;
                    owner_d  = grant;
                    rrPtr_d  = ~grant;
                    latCnt_d = 4'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                latCnt_d = latCnt_q + 4'd1;
                if (latCnt_q == LAT_LAST) begin
                    captureOut = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (ownerRspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= 1'b0;
            owner_q   <= 1'b0;
            latCnt_q  <= 4'd0;
            coreEnc_q <= 1'b0;
            coreIn_q  <= 64'd0;
            coreKey_q <= 128'd0;
            rspData_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            rrPtr_q  <= rrPtr_d;
            owner_q  <= owner_d;
            latCnt_q <= latCnt_d;
            if (loadOps) begin
                coreEnc_q <= grant ? c1_enc  : c0_enc;
                coreIn_q  <= grant ? c1_data : c0_data;
                coreKey_q <= grant ? c1_key  : c0_key;
            end
            if (captureOut) begin
                rspData_q <= core_out;
            end
        end
    end

    // Ready is masked by rst so a client holding valid sees no accept while reset is asserted.
    assign c0_ready     = ~rst & (state_q == IDLE) & c0_valid & ~grant;
    assign c1_ready     = ~rst & (state_q == IDLE) & c1_valid & grant;
    assign c0_rsp_valid = (state_q == RESP) & ~owner_q;
    assign c1_rsp_valid = (state_q == RESP) & owner_q;
    assign busy         = (state_q != IDLE);
    assign rsp_data     = rspData_q;
    assign core_enc     = coreEnc_q;
    assign core_in      = coreIn_q;
    assign core_key     = coreKey_q;

`ifdef PRINCE_ARB_STATS_EN
    logic [15:0] c0Ops_q, c1Ops_q;
    logic        done0, done1;

    assign done0 = (state_q == RESP) & ~owner_q & c0_rsp_ready;
    assign done1 = (state_q == RESP) & owner_q & c1_rsp_ready;

    // A clear wins over a coinciding completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0Ops_q <= 16'd0;
            c1Ops_q <= 16'd0;
        end else if (stats_clr) begin
            c0Ops_q <= 16'd0;
            c1Ops_q <= 16'd0;
        end else begin
            if (done0) c0Ops_q <= c0Ops_q + 16'd1;
            if (done1) c1Ops_q <= c1Ops_q + 16'd1;
        end
    end

    assign c0_ops = c0Ops_q;
    assign c1_ops = c1Ops_q;
`endif

endmodule
